// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic {
    OWN_D,
    OWN_I
  } owner_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and hazard-side signals of the data-memory arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  d_req_i;
  logic                  d_we_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic [2:0]            d_funct3_i;
  logic                  d_done_o;
  logic [DATA_WIDTH-1:0] d_rdata_o;
  logic                  i_req_i;
  logic [ADDR_WIDTH-1:0] i_addr_i;
  logic                  i_done_o;
  logic [DATA_WIDTH-1:0] i_rdata_o;
  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [2:0]            mem_funct3_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  busy_o;

  modport slave (
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_funct3_i,
    output d_done_o, d_rdata_o,
    input  i_req_i, i_addr_i,
    output i_done_o, i_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_funct3_o,
    input  mem_rdata_i,
    output busy_o
  );

  modport master (
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_funct3_i,
    input  d_done_o, d_rdata_o,
    output i_req_i, i_addr_i,
    input  i_done_o, i_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_funct3_o,
    output mem_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Grant selection: D by default, I when alone or once D has used up its win budget.
module mem_arb_pick #(
  parameter int unsigned MAX_D_WINS = 4,
  parameter int unsigned WW         = 3
) (
  input  logic          d_req,
  input  logic          i_req,
  input  logic [WW-1:0] win_cnt,
  output logic          grant_d,
  output logic          grant_i
);
  always_comb begin
    grant_i = i_req && (!d_req || (win_cnt == WW'(MAX_D_WINS)));
    grant_d = d_req && !grant_i;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises D and I accesses onto one data_memory port with a fixed latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned MAX_D_WINS  = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);
  localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned WW = $clog2(MAX_D_WINS + 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LATENCY - 1);
  localparam logic [WW-1:0] WIN_MAX  = WW'(MAX_D_WINS);

  state_t                r_state;
  owner_t                r_owner;
  logic [CW-1:0]         r_cnt;
  logic [WW-1:0]         r_win;
  logic                  r_we;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [2:0]            r_mem_funct3;
  logic                  r_d_done;
  logic                  r_i_done;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic [DATA_WIDTH-1:0] r_i_rdata;
  logic                  r_busy;
  logic                  w_grant_d;
  logic                  w_grant_i;

  mem_arb_pick #(
    .MAX_D_WINS(MAX_D_WINS),
    .WW        (WW)
  ) u_pick (
    .d_req  (bus.d_req_i),
    .i_req  (bus.i_req_i),
    .win_cnt(r_win),
    .grant_d(w_grant_d),
    .grant_i(w_grant_i)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= IDLE;
      r_owner      <= OWN_D;
      r_cnt        <= '0;
      r_win        <= '0;
      r_we         <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_funct3 <= '0;
      r_d_done     <= 1'b0;
      r_i_done     <= 1'b0;
      r_d_rdata    <= '0;
      r_i_rdata    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_d_done <= 1'b0;
      r_i_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_grant_d || w_grant_i) begin
            r_state  <= BUSY;
            r_busy   <= 1'b1;
            r_cnt    <= LAT_LOAD;
            r_mem_en <= 1'b1;
            if (w_grant_i) begin
              r_owner      <= OWN_I;
              r_we         <= 1'b0;
              r_mem_we     <= 1'b0;
              r_mem_addr   <= bus.i_addr_i;
              r_mem_wdata  <= '0;
              r_mem_funct3 <= FUNCT3_WORD;
              r_win        <= '0;
            end else begin
              r_owner      <= OWN_D;
              r_we         <= bus.d_we_i;
              r_mem_we     <= bus.d_we_i;
              r_mem_addr   <= bus.d_addr_i;
              r_mem_wdata  <= bus.d_wdata_i;
              r_mem_funct3 <= bus.d_funct3_i;
              // Count D wins only while I is actually waiting.
              if (!bus.i_req_i)        r_win <= '0;
              else if (r_win != WIN_MAX) r_win <= r_win + WW'(1);
            end
          end
        end
        BUSY: begin
          r_mem_we <= 1'b0;
          if (r_cnt == '0) begin
            if (r_owner == OWN_I)  r_i_rdata <= bus.mem_rdata_i;
            else if (!r_we)        r_d_rdata <= bus.mem_rdata_i;
            r_d_done     <= (r_owner == OWN_D);
            r_i_done     <= (r_owner == OWN_I);
            r_mem_en     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_funct3 <= '0;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.d_done_o     = r_d_done;
  assign bus.d_rdata_o    = r_d_rdata;
  assign bus.i_done_o     = r_i_done;
  assign bus.i_rdata_o    = r_i_rdata;
  assign bus.mem_en_o     = r_mem_en;
  assign bus.mem_we_o     = r_mem_we;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_wdata_o  = r_mem_wdata;
  assign bus.mem_funct3_o = r_mem_funct3;
  assign bus.busy_o       = r_busy;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one MEM_LATENCY=2 instance and one MEM_LATENCY=1 instance.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int unsigned n_chk;
  int unsigned n_pass;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();
  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2), .MAX_D_WINS(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .bus(bus2)
  );
  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .MAX_D_WINS(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_val(input logic [31:0] addr);
    if (addr == 32'h100) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | {16'h0, addr[15:0]};
  endfunction

  // Memory returns junk when not enabled, so a sample outside BUSY is visible.
  assign bus2.mem_rdata_i = bus2.mem_en_o ? rd_val(bus2.mem_addr_o) : 32'hBAD0_BAD0;
  assign bus1.mem_rdata_i = bus1.mem_en_o ? rd_val(bus1.mem_addr_o) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    byte unsigned log_q[$];
    string        exp_s;
    int unsigned  td;
    int unsigned  ti;
    int unsigned  n_idone;

    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    {bus2.d_req_i, bus2.d_we_i, bus2.i_req_i} = '0;
    bus2.d_addr_i = '0; bus2.d_wdata_i = '0; bus2.d_funct3_i = '0; bus2.i_addr_i = '0;
    {bus1.d_req_i, bus1.d_we_i, bus1.i_req_i} = '0;
    bus1.d_addr_i = '0; bus1.d_wdata_i = '0; bus1.d_funct3_i = '0; bus1.i_addr_i = '0;

    tick(); tick();
    check("rst_busy",   {31'b0, bus2.busy_o},   32'd0);
    check("rst_mem_en", {31'b0, bus2.mem_en_o}, 32'd0);
    check("rst_d_done", {31'b0, bus2.d_done_o}, 32'd0);
    check("rst_d_rdata", bus2.d_rdata_o,        32'd0);
    check("rst_i_rdata", bus2.i_rdata_o,        32'd0);
    rst = 1'b1;
    tick();

    // 1: single D read
    bus2.d_req_i = 1'b1; bus2.d_addr_i = 32'h100; bus2.d_funct3_i = 3'b010;
    tick();
    check("t1_en_c1",   {31'b0, bus2.mem_en_o}, 32'd1);
    check("t1_addr",    bus2.mem_addr_o,        32'h100);
    check("t1_we",      {31'b0, bus2.mem_we_o}, 32'd0);
    check("t1_busy",    {31'b0, bus2.busy_o},   32'd1);
    tick();
    check("t1_en_c2",   {31'b0, bus2.mem_en_o}, 32'd1);
    check("t1_early",   {31'b0, bus2.d_done_o}, 32'd0);
    tick();
    check("t1_done",    {31'b0, bus2.d_done_o}, 32'd1);
    check("t1_rdata",   bus2.d_rdata_o,         32'hDEAD_BEEF);
    check("t1_en_resp", {31'b0, bus2.mem_en_o}, 32'd0);
    check("t1_idone",   {31'b0, bus2.i_done_o}, 32'd0);
    bus2.d_req_i = 1'b0;
    tick();
    check("t1_pulse",   {31'b0, bus2.d_done_o}, 32'd0);
    check("t1_idle",    {31'b0, bus2.busy_o},   32'd0);

    // 2: D write
    bus2.d_req_i = 1'b1; bus2.d_we_i = 1'b1; bus2.d_addr_i = 32'h104;
    bus2.d_wdata_i = 32'h1234_5678; bus2.d_funct3_i = 3'b000;
    tick();
    check("t2_we_c1",  {31'b0, bus2.mem_we_o}, 32'd1);
    check("t2_wdata",  bus2.mem_wdata_o,       32'h1234_5678);
    check("t2_funct3", {29'b0, bus2.mem_funct3_o}, 32'd0);
    check("t2_addr",   bus2.mem_addr_o,        32'h104);
    tick();
    check("t2_we_c2",  {31'b0, bus2.mem_we_o}, 32'd0);
    check("t2_en_c2",  {31'b0, bus2.mem_en_o}, 32'd1);
    tick();
    check("t2_done",   {31'b0, bus2.d_done_o}, 32'd1);
    check("t2_rdata",  bus2.d_rdata_o,         32'hDEAD_BEEF);
    bus2.d_req_i = 1'b0; bus2.d_we_i = 1'b0; bus2.d_funct3_i = 3'b010;
    tick();

    // 3: simultaneous requests, D first, I after MEM_LATENCY+2
    bus2.d_req_i = 1'b1; bus2.d_addr_i = 32'h200;
    bus2.i_req_i = 1'b1; bus2.i_addr_i = 32'h300;
    td = 0; ti = 0; n_idone = 0;
    for (int unsigned c = 1; c <= 16; c++) begin
      tick();
      if (bus2.mem_en_o && bus2.mem_addr_o == 32'h300)
        check("t3_i_funct3", {29'b0, bus2.mem_funct3_o}, 32'd2);
      if (bus2.d_done_o) begin
        td = c;
        check("t3_d_rdata", bus2.d_rdata_o, rd_val(32'h200));
        bus2.d_req_i = 1'b0;
      end
      if (bus2.i_done_o) begin
        ti = c;
        n_idone++;
        check("t3_i_rdata", bus2.i_rdata_o, rd_val(32'h300));
        bus2.i_req_i = 1'b0;
      end
    end
    check("t3_d_time", td, 32'd3);
    check("t3_gap",    ti - td, 32'd4);
    check("t3_i_once", n_idone, 32'd1);

    // 4: starvation guard
    bus2.d_req_i = 1'b1; bus2.d_addr_i = 32'h210;
    bus2.i_req_i = 1'b1; bus2.i_addr_i = 32'h310;
    for (int unsigned c = 0; c < 28; c++) begin
      tick();
      if (bus2.d_done_o) log_q.push_back(8'h44);
      if (bus2.i_done_o) begin
        log_q.push_back(8'h49);
        bus2.i_req_i = 1'b0;
      end
    end
    bus2.d_req_i = 1'b0;
    exp_s = "DDDDID";
    check("t4_len", {31'b0, log_q.size() >= 6}, 32'd1);
    for (int unsigned k = 0; k < 6; k++) begin
      check($sformatf("t4_order%0d", k),
            {24'b0, (k < log_q.size()) ? log_q[k] : 8'h00}, {24'b0, exp_s[k]});
    end
    for (int unsigned c = 0; c < 5; c++) tick();

    // 5: reset during the second BUSY cycle of an I read
    bus2.i_req_i = 1'b1; bus2.i_addr_i = 32'h400;
    tick();
    check("t5_funct3", {29'b0, bus2.mem_funct3_o}, 32'd2);
    tick();
    rst = 1'b0; bus2.i_req_i = 1'b0;
    tick();
    check("t5_busy",    {31'b0, bus2.busy_o},   32'd0);
    check("t5_en",      {31'b0, bus2.mem_en_o}, 32'd0);
    check("t5_idone",   {31'b0, bus2.i_done_o}, 32'd0);
    check("t5_addr",    bus2.mem_addr_o,        32'd0);
    check("t5_d_rdata", bus2.d_rdata_o,         32'd0);
    check("t5_i_rdata", bus2.i_rdata_o,         32'd0);
    rst = 1'b1;
    tick();
    check("t5_no_done", {31'b0, bus2.i_done_o}, 32'd0);
    bus2.d_req_i = 1'b1; bus2.d_addr_i = 32'h500;
    tick(); tick(); tick();
    check("t5_d_done",  {31'b0, bus2.d_done_o}, 32'd1);
    check("t5_d_rd",    bus2.d_rdata_o,         rd_val(32'h500));
    bus2.d_req_i = 1'b0;
    tick();

    // 6: MEM_LATENCY=1 instance
    bus1.d_req_i = 1'b1; bus1.d_addr_i = 32'h600; bus1.d_funct3_i = 3'b010;
    tick();
    check("t6_en",    {31'b0, bus1.mem_en_o}, 32'd1);
    check("t6_early", {31'b0, bus1.d_done_o}, 32'd0);
    tick();
    check("t6_done",  {31'b0, bus1.d_done_o}, 32'd1);
    check("t6_rdata", bus1.d_rdata_o,         rd_val(32'h600));
    check("t6_en_off", {31'b0, bus1.mem_en_o}, 32'd0);
    bus1.d_req_i = 1'b0;
    tick();
    check("t6_pulse", {31'b0, bus1.d_done_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
